clock_switch_ctrl: RTL

Sequencer for the glitch-free clock multiplexer that switches the CPU clock between the slow bus clock (clk0 side) and the fast clock (clk1 side). It accepts a level request for fast operation, holds off new bus cycles, waits for the bus to go idle, drives the mux `select`, and confirms completion from the mux's `active0`/`active1` feedback. It runs on a free-running system clock that is never the mux output, and it enforces a minimum dwell time between switches.

---
 rtl/clock_switch_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/clock_switch_ctrl.sv
// Purpose : sequencer for a glitch-free clk0/clk1 mux (hold bus, wait idle, drive select, confirm feedback).
// Latency : select 2 cycles after req_fast (idle bus); done 3 cycles after mux feedback changes.
// Backpr. : hold_bus stalls new bus cycles from request until the switch is confirmed or aborted.
// Ports   : clk/rst (async active-high); req_fast, bus_idle in; active0/active1 async mux feedback;
//           select, hold_bus, busy, is_fast, done (1-cycle pulse), err (sticky watchdog) out.
// Option  : define CLKSW_TIMEOUT_EN to enable the SWITCH-state watchdog (TIMEOUT cycles); else err=0.
module clock_switch_ctrl #(
  parameter int MIN_DWELL = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic req_fast,
  input  logic bus_idle,
  input  logic active0,
  input  logic active1,
  output logic select,
  output logic hold_bus,
  output logic busy,
  output logic is_fast,
  output logic done,
  output logic err
);

  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam logic [DW-1:0] DWELL_INIT = DW'(MIN_DWELL);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

  typedef enum logic [2:0] {
    SLOW, QUIESCE_F, SWITCH_F, FAST, QUIESCE_S, SWITCH_S
  } state_t;

  state_t        state;
  logic [DW-1:0] dwell;
  logic [1:0]    a0_sync;
  logic [1:0]    a1_sync;
  logic          a0_s;
  logic          a1_s;

  assign a0_s = a0_sync[1];
  assign a1_s = a1_sync[1];

`ifdef CLKSW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  logic [TW-1:0] timer;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SLOW;
      dwell    <= '0;
      a0_sync  <= 2'b00;
      a1_sync  <= 2'b00;
      select   <= 1'b0;
      hold_bus <= 1'b0;
      busy     <= 1'b0;
      is_fast  <= 1'b0;
      done     <= 1'b0;
`ifdef CLKSW_TIMEOUT_EN
      timer    <= '0;
      err      <= 1'b0;
`endif
    end else begin
      a0_sync <= {a0_sync[0], active0};
      a1_sync <= {a1_sync[0], active1};
      done    <= 1'b0;
      case (state)
        SLOW: begin
          if (dwell != '0) dwell <= dwell - DWELL_ONE;
          if (req_fast && dwell == '0) begin
            state    <= QUIESCE_F;
            hold_bus <= 1'b1;
            busy     <= 1'b1;
          end
        end
        // req_fast is tested first so a simultaneous drop and bus_idle aborts.
        QUIESCE_F: begin
          if (!req_fast) begin
            state    <= SLOW;
            hold_bus <= 1'b0;
            busy     <= 1'b0;
          end else if (bus_idle) begin
            state  <= SWITCH_F;
            select <= 1'b1;
`ifdef CLKSW_TIMEOUT_EN
            timer  <= '0;
`endif
          end
        end
        // Committed: req_fast ignored until the mux confirms clk1 alone.
        SWITCH_F: begin
          if (a1_s && !a0_s) begin
            state    <= FAST;
            hold_bus <= 1'b0;
            busy     <= 1'b0;
            is_fast  <= 1'b1;
            done     <= 1'b1;
            dwell    <= DWELL_INIT;
          end
`ifdef CLKSW_TIMEOUT_EN
          // Fast side never confirmed: fall back towards clk0.
          else if (timer == TIMER_LAST) begin
            err    <= 1'b1;
            select <= 1'b0;
            state  <= SWITCH_S;
            timer  <= '0;
          end else begin
            timer <= timer + TIMER_ONE;
          end
`endif
        end
        FAST: begin
          if (dwell != '0) dwell <= dwell - DWELL_ONE;
          if (!req_fast && dwell == '0) begin
            state    <= QUIESCE_S;
            hold_bus <= 1'b1;
            busy     <= 1'b1;
            is_fast  <= 1'b0;
          end
        end
        QUIESCE_S: begin
          if (req_fast) begin
            state    <= FAST;
            hold_bus <= 1'b0;
            busy     <= 1'b0;
            is_fast  <= 1'b1;
          end else if (bus_idle) begin
            state  <= SWITCH_S;
            select <= 1'b0;
`ifdef CLKSW_TIMEOUT_EN
            timer  <= '0;
`endif
          end
        end
        SWITCH_S: begin
          if (a0_s && !a1_s) begin
            state    <= SLOW;
            hold_bus <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            dwell    <= DWELL_INIT;
          end
`ifdef CLKSW_TIMEOUT_EN
          // Slow side never confirmed either: give up, release the bus, keep err.
          else if (timer == TIMER_LAST) begin
            err      <= 1'b1;
            state    <= SLOW;
            hold_bus <= 1'b0;
            busy     <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer + TIMER_ONE;
          end
`endif
        end
        default: begin
          state    <= SLOW;
          select   <= 1'b0;
          hold_bus <= 1'b0;
          busy     <= 1'b0;
          is_fast  <= 1'b0;
        end
      endcase
    end
  end

endmodule
